hazard_unit: RTL and testbench

Interlock and flush controller for the non-forwarding five-stage RV32I pipeline (IF, ID, EX, MEM, WB). It tracks the destination registers of instructions in flight in a three-entry scoreboard. It stalls the instruction in ID while a source register has a pending write, and squashes wrong-path instructions when EX resolves a taken branch or jump. It sits beside the decoder: it consumes decoder register-use and write-enable information and drives the enable and flush controls of the PC and pipeline registers.

---
 rtl/hazard_unit.sv | 91 +++++++++
 tb/tb_hazard_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Interlock and flush controller for a non-forwarding 5-stage RV32I pipeline.
// Optional performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module hazard_unit #(
  parameter bit RF_WB_BYPASS = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_vld,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_use,
  input  logic       id_rs2_use,
  input  logic [4:0] id_rd,
  input  logic       id_rd_wren,
  input  logic       ex_br_taken,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       stall
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam bit CHECK_WB = !RF_WB_BYPASS;

  logic       sb_ex_vld, sb_mem_vld, sb_wb_vld;
  logic [4:0] sb_ex_rd, sb_mem_rd, sb_wb_rd;
  logic       rs1_hit, rs2_hit, hazard, issue;

  function automatic logic src_hit(input logic used, input logic [4:0] rs,
                                   input logic vld, input logic [4:0] rd);
    return used & vld & (rs == rd);
  endfunction

  always_comb begin
    rs1_hit = src_hit(id_rs1_use, id_rs1, sb_ex_vld, sb_ex_rd)
            | src_hit(id_rs1_use, id_rs1, sb_mem_vld, sb_mem_rd)
            | (CHECK_WB & src_hit(id_rs1_use, id_rs1, sb_wb_vld, sb_wb_rd));
    rs2_hit = src_hit(id_rs2_use, id_rs2, sb_ex_vld, sb_ex_rd)
            | src_hit(id_rs2_use, id_rs2, sb_mem_vld, sb_mem_rd)
            | (CHECK_WB & src_hit(id_rs2_use, id_rs2, sb_wb_vld, sb_wb_rd));
    hazard     = rs1_hit | rs2_hit;
    // A redirect squashes the ID instruction, so it must not also stall.
    stall      = id_vld & hazard & ~ex_br_taken;
    issue      = id_vld & ~stall & ~ex_br_taken;
    pc_en      = ~stall;
    ifid_en    = ~stall;
    ifid_flush = ex_br_taken;
    idex_flush = stall | ex_br_taken;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_ex_vld  <= 1'b0;
      sb_ex_rd   <= '0;
      sb_mem_vld <= 1'b0;
      sb_mem_rd  <= '0;
      sb_wb_vld  <= 1'b0;
      sb_wb_rd   <= '0;
    end else begin
      sb_wb_vld  <= sb_mem_vld;
      sb_wb_rd   <= sb_mem_rd;
      sb_mem_vld <= sb_ex_vld;
      sb_mem_rd  <= sb_ex_rd;
      if (issue) begin
        sb_ex_vld <= id_rd_wren & (id_rd != 5'd0);
        sb_ex_rd  <= id_rd;
      end else begin
        sb_ex_vld <= 1'b0;
        sb_ex_rd  <= '0;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall)       stall_cnt <= stall_cnt + 32'd1;
      if (ex_br_taken) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: the driver queues expected outputs per cycle,
// a negedge monitor pops and compares them against both bypass configurations.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_vld, id_rs1_use, id_rs2_use, id_rd_wren, ex_br_taken;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       pc_en, ifid_en, ifid_flush, idex_flush, stall;
  logic       pc_en0, ifid_en0, ifid_flush0, idex_flush0, stall0;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt, stall_cnt0, flush_cnt0;
`endif

  always #5 clk = ~clk;

  hazard_unit #(.RF_WB_BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .id_vld(id_vld), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use), .id_rd(id_rd),
    .id_rd_wren(id_rd_wren), .ex_br_taken(ex_br_taken), .pc_en(pc_en),
    .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .stall(stall)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  hazard_unit #(.RF_WB_BYPASS(1'b0)) dut0 (
    .clk(clk), .rst(rst), .id_vld(id_vld), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use), .id_rd(id_rd),
    .id_rd_wren(id_rd_wren), .ex_br_taken(ex_br_taken), .pc_en(pc_en0),
    .ifid_en(ifid_en0), .ifid_flush(ifid_flush0), .idex_flush(idex_flush0),
    .stall(stall0)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
`endif
  );

  // Output vector order: {stall, pc_en, ifid_en, ifid_flush, idex_flush}
  localparam logic [4:0] IDLE = 5'b01100;
  localparam logic [4:0] STL  = 5'b10001;
  localparam logic [4:0] FLS  = 5'b01111;

  // kind 0: bypass DUT outputs, 1: no-bypass DUT outputs, 2: stall_cnt, 3: flush_cnt
  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t        q[$];
  exp_t        e_m;
  logic [31:0] act_m;
  int          checks = 0;
  int          failures = 0;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      e_m = q.pop_front();
      case (e_m.kind)
        0: act_m = {27'd0, stall, pc_en, ifid_en, ifid_flush, idex_flush};
        1: act_m = {27'd0, stall0, pc_en0, ifid_en0, ifid_flush0, idex_flush0};
`ifdef HAZARD_PERF_CNT_EN
        2: act_m = stall_cnt;
        3: act_m = flush_cnt;
`endif
        default: act_m = 'x;
      endcase
      checks++;
      if (act_m !== e_m.exp) begin
        failures++;
        $display("FAIL %s: actual=%h expected=%h", e_m.name, act_m, e_m.exp);
      end
    end
  end

  task automatic push(input string nm, input int kind, input logic [31:0] ex);
    exp_t e;
    e.name = nm;
    e.kind = kind;
    e.exp  = ex;
    q.push_back(e);
  endtask

  // One pipeline cycle: present the ID instruction, queue its expected outputs.
  task automatic cyc(input string nm, input logic v, input logic [4:0] r1,
                     input logic u1, input logic [4:0] r2, input logic u2,
                     input logic [4:0] rd, input logic w, input logic br,
                     input int kind, input logic [4:0] ex);
    id_vld = v; id_rs1 = r1; id_rs1_use = u1; id_rs2 = r2; id_rs2_use = u2;
    id_rd = rd; id_rd_wren = w; ex_br_taken = br;
    push(nm, kind, {27'd0, ex});
    @(posedge clk); #1;
  endtask

  task automatic idle(input string nm, input int kind, input int n);
    for (int i = 0; i < n; i++) cyc(nm, 0, 0, 0, 0, 0, 0, 0, 0, kind, IDLE);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    id_vld = 0; id_rs1 = 0; id_rs1_use = 0; id_rs2 = 0; id_rs2_use = 0;
    id_rd = 0; id_rd_wren = 0; ex_br_taken = 0;
    push("reset_outs", 0, {27'd0, IDLE});
    push("reset_outs_nobyp", 1, {27'd0, IDLE});
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // addi x5,x0,1 ; add x6,x5,x5 -> 2 stall cycles
    cyc("raw1_addi", 1, 0, 1, 0, 0, 5, 1, 0, 0, IDLE);
    cyc("raw1_stall1", 1, 5, 1, 5, 1, 6, 1, 0, 0, STL);
    cyc("raw1_stall2", 1, 5, 1, 5, 1, 6, 1, 0, 0, STL);
    cyc("raw1_issue", 1, 5, 1, 5, 1, 6, 1, 0, 0, IDLE);
    idle("raw1_drain", 0, 1);
    cyc("br_only", 0, 0, 0, 0, 0, 0, 0, 1, 0, FLS);
`ifdef HAZARD_PERF_CNT_EN
    push("stall_cnt_2", 2, 32'd2);
    push("flush_cnt_1", 3, 32'd1);
`endif
    idle("raw1_drain2", 0, 3);

    // addi x0,x0,5 ; add x6,x0,x0 -> x0 never matches
    cyc("x0_addi", 1, 0, 1, 0, 0, 0, 1, 0, 0, IDLE);
    cyc("x0_add", 1, 0, 1, 0, 1, 6, 1, 0, 0, IDLE);
    idle("x0_drain", 0, 3);

    // lw x7,0(x2) ; nop ; sub x8,x7,x1 -> 1 stall
    cyc("d2_lw", 1, 2, 1, 0, 0, 7, 1, 0, 0, IDLE);
    cyc("d2_nop", 1, 0, 1, 0, 0, 0, 1, 0, 0, IDLE);
    cyc("d2_stall", 1, 7, 1, 1, 1, 8, 1, 0, 0, STL);
    cyc("d2_issue", 1, 7, 1, 1, 1, 8, 1, 0, 0, IDLE);
    idle("d2_drain", 0, 3);

    // lw x7 ; lui x9 (no sources) -> no stall
    cyc("lui_lw", 1, 2, 1, 0, 0, 7, 1, 0, 0, IDLE);
    cyc("lui_nostall", 1, 7, 0, 7, 0, 9, 1, 0, 0, IDLE);
    idle("lui_drain", 0, 3);

    // lw x7 ; add x10,x1,x7 -> rs2 hazard, 2 stalls
    cyc("rs2_lw", 1, 2, 1, 0, 0, 7, 1, 0, 0, IDLE);
    cyc("rs2_stall1", 1, 1, 1, 7, 1, 10, 1, 0, 0, STL);
    cyc("rs2_stall2", 1, 1, 1, 7, 1, 10, 1, 0, 0, STL);
    cyc("rs2_issue", 1, 1, 1, 7, 1, 10, 1, 0, 0, IDLE);
    idle("rs2_drain", 0, 3);

    // lw x7 ; addi x11,x1,7 whose rs2 field aliases x7 but is unused
    cyc("unused_lw", 1, 2, 1, 0, 0, 7, 1, 0, 0, IDLE);
    cyc("unused_rs2", 1, 1, 1, 7, 0, 11, 1, 0, 0, IDLE);
    idle("unused_drain", 0, 3);

    // addi x12 ; addi x13 ; add x14,x12,x13 -> youngest writer sets 2 stalls
    cyc("b2b_x12", 1, 0, 1, 0, 0, 12, 1, 0, 0, IDLE);
    cyc("b2b_x13", 1, 0, 1, 0, 0, 13, 1, 0, 0, IDLE);
    cyc("b2b_stall1", 1, 12, 1, 13, 1, 14, 1, 0, 0, STL);
    cyc("b2b_stall2", 1, 12, 1, 13, 1, 14, 1, 0, 0, STL);
    cyc("b2b_issue", 1, 12, 1, 13, 1, 14, 1, 0, 0, IDLE);
    idle("b2b_drain", 0, 3);

    // jal x1 ; hazard in ID during redirect -> flush wins; jal rd still tracked
    cyc("jal_issue", 1, 0, 0, 0, 0, 1, 1, 0, 0, IDLE);
    cyc("jal_flush", 1, 1, 1, 0, 1, 2, 1, 1, 0, FLS);
    cyc("jal_rd_tracked", 1, 1, 1, 0, 1, 3, 1, 0, 0, STL);
    cyc("jal_target_issue", 1, 1, 1, 0, 1, 3, 1, 0, 0, IDLE);
    idle("jal_drain", 0, 3);

    // Squashed wrong-path writer must leave a bubble, not its rd
    cyc("sq_flush", 1, 0, 1, 0, 0, 20, 1, 1, 0, FLS);
    cyc("sq_no_stall", 1, 20, 1, 0, 1, 21, 1, 0, 0, IDLE);
    idle("sq_drain", 0, 3);

    // Reset asserted during the second stall cycle
    cyc("rst_addi", 1, 0, 1, 0, 0, 5, 1, 0, 0, IDLE);
    cyc("rst_stall1", 1, 5, 1, 5, 1, 6, 1, 0, 0, STL);
    rst = 1'b1;
    cyc("rst_mid_stall", 1, 5, 1, 5, 1, 6, 1, 0, 0, IDLE);
    rst = 1'b0;
    cyc("rst_after_issue", 1, 5, 1, 5, 1, 6, 1, 0, 0, IDLE);
    idle("rst_drain", 0, 3);

    // No-bypass configuration: WB entry checked, 3 stall cycles
    do_reset();
    cyc("nb_addi", 1, 0, 1, 0, 0, 5, 1, 0, 1, IDLE);
    cyc("nb_stall1", 1, 5, 1, 5, 1, 6, 1, 0, 1, STL);
    cyc("nb_stall2", 1, 5, 1, 5, 1, 6, 1, 0, 1, STL);
    cyc("nb_stall3", 1, 5, 1, 5, 1, 6, 1, 0, 1, STL);
    cyc("nb_issue", 1, 5, 1, 5, 1, 6, 1, 0, 1, IDLE);
    idle("nb_drain", 1, 4);
    cyc("nb_d3_lw", 1, 2, 1, 0, 0, 7, 1, 0, 1, IDLE);
    idle("nb_d3_gap", 1, 2);
    cyc("nb_d3_stall", 1, 7, 1, 1, 1, 8, 1, 0, 1, STL);
    cyc("nb_d3_issue", 1, 7, 1, 1, 1, 8, 1, 0, 1, IDLE);
    idle("nb_d3_drain", 1, 4);

`ifdef HAZARD_PERF_CNT_EN
    // stall_cnt wraps from all-ones to zero on one stall cycle
    do_reset();
    force dut.stall_cnt = 32'hFFFF_FFFF;
    #1 release dut.stall_cnt;
    push("wrap_preload", 2, 32'hFFFF_FFFF);
    cyc("wrap_lw", 1, 2, 1, 0, 0, 7, 1, 0, 0, IDLE);
    cyc("wrap_nop", 1, 0, 1, 0, 0, 0, 1, 0, 0, IDLE);
    cyc("wrap_stall", 1, 7, 1, 1, 1, 8, 1, 0, 0, STL);
    push("wrap_cnt_0", 2, 32'd0);
    cyc("wrap_issue", 1, 7, 1, 1, 1, 8, 1, 0, 0, IDLE);
    idle("wrap_drain", 0, 2);
`endif

    @(posedge clk); #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: actual=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
